// File: rtl/display_pkg.sv
// Shared constants and helpers for the display word selector and its
// button debouncers.
package display_pkg;

    // Width of every debug word and of the hex converter input.
    localparam int WORD_W = 32;

    // Roughly 10 ms at 50 MHz, enough to swallow contact bounce.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a one-cycle pulse on the debounced rising edge.
module key_debouncer
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int               CNT_W = idx_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES;
    // the rise pulse fires in the same cycle the level flips to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync;
                rise  <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_word_selector.sv
// Selects one of NUM_SRC debug words for the hex display converter.
// Buttons step the selection, freeze_sw holds the displayed value.
// Optional DISP_AUTOSCROLL_EN adds a timed automatic advance.
module display_word_selector
    import display_pkg::*;
#(
    parameter  int NUM_SRC         = 4,
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter  int AUTO_CYCLES     = 50000000,
    localparam int IDXW            = idx_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*WORD_W-1:0] src_flat,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    input  logic                      freeze_sw,
    output logic [WORD_W-1:0]         data_out,
    output logic [IDXW-1:0]           sel_idx
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SRC - 1);

    if (NUM_SRC < 2 || NUM_SRC > 16 || DEBOUNCE_CYCLES < 2 || AUTO_CYCLES < 1) begin : g_param_check
        $error("display_word_selector: illegal parameter value");
    end

    logic              frz_meta;
    logic              frozen;
    logic              nxt_p;
    logic              prv_p;
    logic              auto_p;
    logic              step_fwd;
    logic              step_bwd;
    logic [WORD_W-1:0] cur_word;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next),
        .rise  (nxt_p)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_prev),
        .rise  (prv_p)
    );

    // The slide switch does not bounce in a way that matters; sync only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_meta <= 1'b0;
            frozen   <= 1'b0;
        end else begin
            frz_meta <= freeze_sw;
            frozen   <= frz_meta;
        end
    end

`ifdef DISP_AUTOSCROLL_EN
    localparam int                AUTO_W    = idx_width(AUTO_CYCLES);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

    logic [AUTO_W-1:0] auto_cnt;

    assign auto_p = (auto_cnt == AUTO_LAST);

    // Interval timer: frozen holds it, a button press restarts the interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!frozen) begin
            if (nxt_p || prv_p || auto_p) auto_cnt <= '0;
            else                          auto_cnt <= auto_cnt + 1'b1;
        end
    end
`else
    assign auto_p = 1'b0;
`endif

    // Opposing requests cancel; a prev press overrides an auto advance.
    assign step_fwd = (nxt_p | auto_p) & ~prv_p;
    assign step_bwd = prv_p & ~nxt_p;

    // sel_idx is kept in 0..NUM_SRC-1, so the part-select never overruns.
    assign cur_word = src_flat[int'(sel_idx)*WORD_W +: WORD_W];

    // Selection index with explicit wrap for non-power-of-two NUM_SRC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_idx <= '0;
        end else if (!frozen) begin
            if (step_fwd)
                sel_idx <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
            else if (step_bwd)
                sel_idx <= (sel_idx == '0) ? LAST_IDX : sel_idx - 1'b1;
        end
    end

    // Registered word to the converter; held while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       data_out <= '0;
        else if (!frozen) data_out <= cur_word;
    end

endmodule

// File: tb/tb_display_word_selector.sv
// Self-checking bench for display_word_selector (NUM_SRC=4, DEBOUNCE_CYCLES=4,
// AUTO_CYCLES=20). With DISP_AUTOSCROLL_EN defined, the auto-advance
// scenario replaces the button scenarios.
module tb_display_word_selector;

    localparam int NUM_SRC = 4;
    localparam int DEB     = 4;
    localparam int AUTO    = 20;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_SRC*32-1:0] src_flat;
    logic                  btn_next = 1'b0;
    logic                  btn_prev = 1'b0;
    logic                  freeze_sw = 1'b0;
    logic [31:0]           data_out;
    logic [1:0]            sel_idx;

    logic [31:0] words [NUM_SRC];

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    display_word_selector #(
        .NUM_SRC         (NUM_SRC),
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_CYCLES     (AUTO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_flat  (src_flat),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .freeze_sw (freeze_sw),
        .data_out  (data_out),
        .sel_idx   (sel_idx)
    );

    always #5 clk = ~clk;

    always_comb src_flat = {words[3], words[2], words[1], words[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then step 1 time unit away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [1:0] i);
        exp_t e;
        e.tag  = tag;
        e.data = d;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".data"}, data_out, e.data);
        check({e.tag, ".idx"}, 32'(sel_idx), 32'(e.idx));
    endtask

    // Clean press: hold long enough to debounce, then release and settle.
    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    initial begin
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;

        tick(2);
        expect_out("reset", 32'h0, 2'd0);
        sample();
        rst_n = 1'b1;
        tick(1);
        expect_out("rst_release", 32'h11111111, 2'd0);
        sample();

`ifdef DISP_AUTOSCROLL_EN
        tick(18);
        expect_out("auto_before_tc", 32'h11111111, 2'd0);
        sample();
        tick(1);
        expect_out("auto_step_idx", 32'h11111111, 2'd1);
        sample();
        tick(1);
        expect_out("auto_step_data", 32'h22222222, 2'd1);
        sample();
        freeze_sw = 1'b1;
        tick(30);
        expect_out("auto_frozen", 32'h22222222, 2'd1);
        sample();
        freeze_sw = 1'b0;
        tick(5);
        expect_out("auto_resume", 32'h22222222, 2'd1);
        sample();
        tick(20);
        expect_out("auto_second", 32'h33333333, 2'd2);
        sample();
`else
        // Bounce: level never stable for DEB cycles until finally held.
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        btn_next = 1'b1;
        tick(12);
        expect_out("bounce", 32'h22222222, 2'd1);
        sample();
        tick(20);
        expect_out("hold_one_step", 32'h22222222, 2'd1);
        sample();
        btn_next = 1'b0;
        tick(10);

        press(1'b0, 1'b1);
        expect_out("prev_back", 32'h11111111, 2'd0);
        sample();

        for (int i = 1; i <= 4; i++) begin
            press(1'b1, 1'b0);
            expect_out($sformatf("wrap_next%0d", i), words[i % 4], 2'(i % 4));
            sample();
        end

        press(1'b0, 1'b1);
        expect_out("wrap_prev", 32'h44444444, 2'd3);
        sample();

        press(1'b1, 1'b1);
        expect_out("simultaneous", 32'h44444444, 2'd3);
        sample();

        press(1'b1, 1'b0);
        expect_out("next_to_0", 32'h11111111, 2'd0);
        sample();

        freeze_sw = 1'b1;
        tick(4);
        words[0] = 32'hDEADBEEF;
        tick(2);
        press(1'b1, 1'b0);
        expect_out("frozen", 32'h11111111, 2'd0);
        sample();
        freeze_sw = 1'b0;
        tick(4);
        expect_out("unfreeze", 32'hDEADBEEF, 2'd0);
        sample();

        words[0] = 32'hCAFEF00D;
        tick(1);
        expect_out("src_latency", 32'hCAFEF00D, 2'd0);
        sample();

        words[0] = 32'h11111111;
        press(1'b1, 1'b0);
        expect_out("pre_reset", 32'h22222222, 2'd1);
        sample();

        #3;
        rst_n = 1'b0;
        #1;
        expect_out("mid_reset", 32'h0, 2'd0);
        sample();
        tick(3);
        expect_out("reset_held", 32'h0, 2'd0);
        sample();
        rst_n = 1'b1;
        tick(1);
        expect_out("reset_release2", 32'h11111111, 2'd0);
        sample();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
